// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM arbiter.
package sdram_arb_pkg;
   localparam int ADDR_W_DEF = 25;
   localparam int DATA_W_DEF = 8;

   typedef logic req_id_t;

   typedef enum logic {
      IDLE,
      ISSUE
   } arb_state_t;
endpackage

// File: rtl/sdram_rd_id_fifo.sv
// Holds the requester ID of every read accepted by the SDRAM controller and
// not yet returned, so return data can be routed back in order.
module sdram_rd_id_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  req_id_t          push_id,
   input  logic             pop,
   output req_id_t          head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   req_id_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // a pop in the same cycle frees the slot a push at full needs
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr] <= push_id;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem_q[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter merging two Avalon-MM requesters onto one SDRAM
// controller port, routing pipelined read data back to its requester.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | pick an eligible requester, latch its command into m_ regs
//   ISSUE | hold m_ command until the controller drops waitrequest
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_PEND = 4
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [ADDR_W-1:0] r0_address,
   input  logic              r0_read,
   input  logic              r0_write,
   input  logic [DATA_W-1:0] r0_writedata,
   output logic              r0_waitrequest,
   output logic [DATA_W-1:0] r0_readdata,
   output logic              r0_readdatavalid,
   input  logic [ADDR_W-1:0] r1_address,
   input  logic              r1_read,
   input  logic              r1_write,
   input  logic [DATA_W-1:0] r1_writedata,
   output logic              r1_waitrequest,
   output logic [DATA_W-1:0] r1_readdata,
   output logic              r1_readdatavalid,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   input  logic              m_waitrequest,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_readdatavalid,
   output logic              err
);

   localparam int CNT_W = $clog2(MAX_PEND) + 1;

   arb_state_t        state;
   req_id_t           ptr;
   req_id_t           gnt_id;
   req_id_t           pick_id;
   req_id_t           fifo_head;
   logic [CNT_W-1:0]  pend_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              rd_room;
   logic              elig0;
   logic              elig1;
   logic              accept;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_rd;
   logic              sel_wr;

   // read+write together counts as a read, so it is gated by read room
   assign rd_room = (pend_cnt < CNT_W'(MAX_PEND));
   assign elig0   = r0_read ? rd_room : r0_write;
   assign elig1   = r1_read ? rd_room : r1_write;

   always_comb begin
      pick_id = ptr;
      if (elig0 && !elig1)
         pick_id = 1'b0;
      else if (elig1 && !elig0)
         pick_id = 1'b1;
   end

   assign sel_addr  = (pick_id == 1'b1) ? r1_address   : r0_address;
   assign sel_wdata = (pick_id == 1'b1) ? r1_writedata : r0_writedata;
   assign sel_rd    = (pick_id == 1'b1) ? r1_read      : r0_read;
   assign sel_wr    = (pick_id == 1'b1) ? r1_write     : r0_write;

   assign accept         = (state == ISSUE) && !m_waitrequest;
   assign r0_waitrequest = !(accept && (gnt_id == 1'b0));
   assign r1_waitrequest = !(accept && (gnt_id == 1'b1));
   assign fifo_push      = accept && m_read;

   sdram_rd_id_fifo #(
      .DEPTH (MAX_PEND)
   ) u_id_fifo (
      .clk     (clk_clk),
      .rst     (reset_reset),
      .push    (fifo_push),
      .push_id (gnt_id),
      .pop     (m_readdatavalid),
      .head    (fifo_head),
      .count   (pend_cnt),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state            <= IDLE;
         ptr              <= 1'b0;
         gnt_id           <= 1'b0;
         m_address        <= '0;
         m_writedata      <= '0;
         m_read           <= 1'b0;
         m_write          <= 1'b0;
         r0_readdata      <= '0;
         r1_readdata      <= '0;
         r0_readdatavalid <= 1'b0;
         r1_readdatavalid <= 1'b0;
         err              <= 1'b0;
      end else begin
         r0_readdatavalid <= 1'b0;
         r1_readdatavalid <= 1'b0;

         if (m_readdatavalid) begin
            if (fifo_empty) begin
               err <= 1'b1;
            end else if (fifo_head == 1'b0) begin
               r0_readdata      <= m_readdata;
               r0_readdatavalid <= 1'b1;
            end else begin
               r1_readdata      <= m_readdata;
               r1_readdatavalid <= 1'b1;
            end
         end

         if ((r0_read && r0_write) || (r1_read && r1_write))
            err <= 1'b1;
         // defensive: an accepted read with no free ID slot would lose routing
         if (fifo_push && fifo_full && !m_readdatavalid)
            err <= 1'b1;

         case (state)
            IDLE: begin
               if (elig0 || elig1) begin
                  m_address   <= sel_addr;
                  m_writedata <= sel_wdata;
                  m_read      <= sel_rd;
                  m_write     <= sel_wr && !sel_rd;
                  gnt_id      <= pick_id;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (!m_waitrequest) begin
                  m_read  <= 1'b0;
                  m_write <= 1'b0;
                  ptr     <= ~gnt_id;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: scenario tasks plus a per-cycle scoreboard
// built from an SDRAM slave model and per-requester expected-data queues.
module tb_sdram_port_arbiter;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic [24:0] r_addr [2];
   logic        r_rd   [2];
   logic        r_wr   [2];
   logic [7:0]  r_wd   [2];
   logic        r_wait [2];
   logic [7:0]  r_rdata[2];
   logic        r_rdv  [2];
   logic [24:0] m_address;
   logic        m_read;
   logic        m_write;
   logic [7:0]  m_writedata;
   logic        m_waitrequest;
   logic [7:0]  m_readdata;
   logic        m_readdatavalid;
   logic        err;

   int          checks   = 0;
   int          failures = 0;
   int          wait_pct = 0;
   int          rdv_pct  = 0;
   bit          rdv_once = 0;
   bit          rdv_spurious = 0;
   int          req_mode [2];
   bit          busy     [2];
   logic [24:0] slave_q[$];
   logic [7:0]  exp_q0[$];
   logic [7:0]  exp_q1[$];
   int          grant_log[$];

   always #5 clk_clk = ~clk_clk;

   sdram_port_arbiter dut (
      .clk_clk          (clk_clk),
      .reset_reset      (reset_reset),
      .r0_address       (r_addr[0]),
      .r0_read          (r_rd[0]),
      .r0_write         (r_wr[0]),
      .r0_writedata     (r_wd[0]),
      .r0_waitrequest   (r_wait[0]),
      .r0_readdata      (r_rdata[0]),
      .r0_readdatavalid (r_rdv[0]),
      .r1_address       (r_addr[1]),
      .r1_read          (r_rd[1]),
      .r1_write         (r_wr[1]),
      .r1_writedata     (r_wd[1]),
      .r1_waitrequest   (r_wait[1]),
      .r1_readdata      (r_rdata[1]),
      .r1_readdatavalid (r_rdv[1]),
      .m_address        (m_address),
      .m_read           (m_read),
      .m_write          (m_write),
      .m_writedata      (m_writedata),
      .m_waitrequest    (m_waitrequest),
      .m_readdata       (m_readdata),
      .m_readdatavalid  (m_readdatavalid),
      .err              (err)
   );

   // contents of the model SDRAM
   function automatic logic [7:0] mem_data(input logic [24:0] a);
      return a[7:0] ^ a[15:8] ^ a[24:17] ^ 8'h3C;
   endfunction

   // One clock: drive slave inputs at negedge, observe #1 later, score, and
   // let auto requesters choose their next command.
   task automatic step();
      logic       acc_m;
      logic [7:0] e;
      @(negedge clk_clk);
      m_waitrequest   = ($urandom_range(99) < wait_pct);
      m_readdatavalid = 1'b0;
      m_readdata      = 8'($urandom);
      if (rdv_spurious) begin
         m_readdatavalid = 1'b1;
         m_readdata      = 8'h5A;
         rdv_spurious    = 0;
      end else if (slave_q.size() > 0 && (rdv_once || $urandom_range(99) < rdv_pct)) begin
         m_readdatavalid = 1'b1;
         m_readdata      = mem_data(slave_q.pop_front());
         rdv_once        = 0;
      end
      #1;
      if (reset_reset) return;
      acc_m = (m_read || m_write) && !m_waitrequest;
      for (int n = 0; n < 2; n++) begin
         if (r_rdv[n] === 1'b1) begin
            checks++;
            if ((n == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
               failures++;
               $display("FAIL rdv_unexpected r%0d got data=%h, required no strobe", n, r_rdata[n]);
            end else begin
               e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               if (r_rdata[n] !== e) begin
                  failures++;
                  $display("FAIL rdv_data r%0d got=%h required=%h", n, r_rdata[n], e);
               end
            end
         end
         if (r_wait[n] === 1'b0) begin
            checks++;
            if (!acc_m || m_address !== r_addr[n] || m_read !== r_rd[n] ||
                m_write !== (r_wr[n] & ~r_rd[n]) || (m_write && m_writedata !== r_wd[n])) begin
               failures++;
               $display("FAIL accept_cmd r%0d got m_rd=%b m_wr=%b addr=%h wd=%h required rd=%b wr=%b addr=%h wd=%h",
                        n, m_read, m_write, m_address, m_writedata, r_rd[n], r_wr[n] & ~r_rd[n], r_addr[n], r_wd[n]);
            end
            if (r_rd[n]) begin
               if (n == 0) exp_q0.push_back(mem_data(r_addr[n]));
               else        exp_q1.push_back(mem_data(r_addr[n]));
            end
            grant_log.push_back(n);
         end
      end
      if (acc_m) begin
         checks++;
         if (r_wait[0] === r_wait[1]) begin
            failures++;
            $display("FAIL accept_onehot got wait0=%b wait1=%b required exactly one low", r_wait[0], r_wait[1]);
         end
         if (m_read) slave_q.push_back(m_address);
      end
      for (int n = 0; n < 2; n++) begin
         if (req_mode[n] != 0) begin
            if (r_wait[n] === 1'b0) busy[n] = 0;
            if (!busy[n]) begin
               r_rd[n] = 1'b0;
               r_wr[n] = 1'b0;
               if (req_mode[n] == 1) begin
                  r_rd[n]   = 1'b1;
                  r_addr[n] = 25'($urandom);
                  busy[n]   = 1;
               end else if (req_mode[n] == 2 && $urandom_range(1) == 1) begin
                  if ($urandom_range(1) == 1) r_rd[n] = 1'b1;
                  else                        r_wr[n] = 1'b1;
                  r_addr[n] = 25'($urandom);
                  r_wd[n]   = 8'($urandom);
                  busy[n]   = 1;
               end
            end
         end
      end
   endtask

   task automatic clear_model();
      slave_q.delete();
      exp_q0.delete();
      exp_q1.delete();
      grant_log.delete();
      for (int n = 0; n < 2; n++) begin
         req_mode[n] = 0;
         busy[n]     = 0;
         r_rd[n]     = 1'b0;
         r_wr[n]     = 1'b0;
         r_addr[n]   = '0;
         r_wd[n]     = '0;
      end
      rdv_once     = 0;
      rdv_spurious = 0;
   endtask

   task automatic do_reset();
      clear_model();
      wait_pct    = 0;
      rdv_pct     = 0;
      reset_reset = 1'b1;
      step();
      step();
      reset_reset = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      req_mode[0] = 3;
      req_mode[1] = 3;
      wait_pct    = 0;
      rdv_pct     = 100;
      for (int t = 0; t < 200; t++) begin
         if (!busy[0] && !busy[1] && exp_q0.size() == 0 && exp_q1.size() == 0 && slave_q.size() == 0) begin
            done = 1;
            break;
         end
         step();
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL drain_timeout got pending r0=%0d r1=%0d slave=%0d required 0",
                  exp_q0.size(), exp_q1.size(), slave_q.size());
      end
      req_mode[0] = 0;
      req_mode[1] = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (err !== 1'b0 || r_wait[0] !== 1'b1 || r_wait[1] !== 1'b1 || m_read !== 1'b0 ||
          m_write !== 1'b0 || m_address !== 25'h0 || m_writedata !== 8'h0) begin
         failures++;
         $display("FAIL reset_ctrl got err=%b wait=%b%b m_rd=%b m_wr=%b addr=%h wd=%h required 0 11 0 0 0 0",
                  err, r_wait[0], r_wait[1], m_read, m_write, m_address, m_writedata);
      end
      checks++;
      if (r_rdv[0] !== 1'b0 || r_rdv[1] !== 1'b0 || r_rdata[0] !== 8'h0 || r_rdata[1] !== 8'h0) begin
         failures++;
         $display("FAIL reset_ret got rdv=%b%b rdata=%h/%h required 00 00/00",
                  r_rdv[0], r_rdv[1], r_rdata[0], r_rdata[1]);
      end
      step();
      checks++;
      if (m_read !== 1'b0 || m_write !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got m_rd=%b m_wr=%b required 0 0", m_read, m_write);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      r_wr[1]   = 1'b1;
      r_addr[1] = 25'h0123456;
      r_wd[1]   = 8'hA5;
      step();
      checks++;
      if (m_write !== 1'b1 || m_read !== 1'b0 || r_wait[1] !== 1'b0 || r_wait[0] !== 1'b1 ||
          m_address !== 25'h0123456 || m_writedata !== 8'hA5) begin
         failures++;
         $display("FAIL single_write got m_wr=%b m_rd=%b wait1=%b wait0=%b addr=%h wd=%h required 1 0 0 1 0123456 a5",
                  m_write, m_read, r_wait[1], r_wait[0], m_address, m_writedata);
      end
      r_wr[1] = 1'b0;
      step();
      checks++;
      if (m_write !== 1'b0 || r_wait[1] !== 1'b1) begin
         failures++;
         $display("FAIL single_write_idle got m_wr=%b wait1=%b required 0 1", m_write, r_wait[1]);
      end
   endtask

   task automatic test_contention();
      do_reset();
      rdv_pct     = 50;
      req_mode[0] = 1;
      req_mode[1] = 1;
      repeat (40) step();
      drain();
      checks++;
      if (grant_log.size() < 10) begin
         failures++;
         $display("FAIL contention_count got grants=%0d required >=10", grant_log.size());
      end
      for (int i = 0; i < grant_log.size(); i++) begin
         checks++;
         if (grant_log[i] != i % 2) begin
            failures++;
            $display("FAIL contention_order grant %0d got r%0d required r%0d", i, grant_log[i], i % 2);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      wait_pct  = 100;
      r_rd[0]   = 1'b1;
      r_addr[0] = 25'h0ABCDE3;
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (m_read !== 1'b1 || m_write !== 1'b0 || m_address !== 25'h0ABCDE3 || r_wait[0] !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_hold cycle %0d got m_rd=%b m_wr=%b addr=%h wait0=%b required 1 0 0abcde3 1",
                     i, m_read, m_write, m_address, r_wait[0]);
         end
         if (i < 4) step();
      end
      wait_pct = 0;
      step();
      checks++;
      if (r_wait[0] !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release got wait0=%b required 0", r_wait[0]);
      end
      r_rd[0] = 1'b0;
      step();
      rdv_once = 1;
      step();
      step();
      checks++;
      if (exp_q0.size() != 0) begin
         failures++;
         $display("FAIL backpressure_return got outstanding=%0d required 0", exp_q0.size());
      end
   endtask

   task automatic test_pending_limit();
      bit got;
      bit stalled;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         r_rd[0]   = 1'b1;
         r_addr[0] = 25'h0000100 + 25'(k);
         got = 0;
         for (int t = 0; t < 4; t++) begin
            step();
            if (r_wait[0] === 1'b0) begin
               got = 1;
               break;
            end
         end
         r_rd[0] = 1'b0;
         checks++;
         if (!got) begin
            failures++;
            $display("FAIL pend_accept read %0d got no accept required accept", k);
         end
      end
      r_rd[0]   = 1'b1;
      r_addr[0] = 25'h0000104;
      stalled   = 1;
      repeat (6) begin
         step();
         if (r_wait[0] !== 1'b1 || m_read !== 1'b0) stalled = 0;
      end
      checks++;
      if (!stalled) begin
         failures++;
         $display("FAIL pend_stall got fifth read issued required stalled at 4 pending");
      end
      rdv_once = 1;
      step();
      step();
      checks++;
      if (r_rdv[0] !== 1'b1 || m_read !== 1'b0) begin
         failures++;
         $display("FAIL pend_return got rdv0=%b m_rd=%b required 1 0", r_rdv[0], m_read);
      end
      step();
      checks++;
      if (m_read !== 1'b1 || r_wait[0] !== 1'b0) begin
         failures++;
         $display("FAIL pend_retry got m_rd=%b wait0=%b required 1 0", m_read, r_wait[0]);
      end
      r_rd[0] = 1'b0;
      drain();
   endtask

   task automatic test_errors();
      do_reset();
      rdv_spurious = 1;
      step();
      step();
      checks++;
      if (err !== 1'b1 || r_rdv[0] !== 1'b0 || r_rdv[1] !== 1'b0) begin
         failures++;
         $display("FAIL err_spurious got err=%b rdv=%b%b required 1 00", err, r_rdv[0], r_rdv[1]);
      end
      wait_pct  = 100;
      r_rd[1]   = 1'b1;
      r_addr[1] = 25'h0000055;
      step();
      step();
      checks++;
      if (m_read !== 1'b1) begin
         failures++;
         $display("FAIL err_preload got m_rd=%b required 1", m_read);
      end
      reset_reset = 1'b1;
      r_rd[1]     = 1'b0;
      step();
      checks++;
      if (err !== 1'b0 || r_wait[0] !== 1'b1 || r_wait[1] !== 1'b1 || m_read !== 1'b0 || m_write !== 1'b0) begin
         failures++;
         $display("FAIL err_reset got err=%b wait=%b%b m_rd=%b m_wr=%b required 0 11 0 0",
                  err, r_wait[0], r_wait[1], m_read, m_write);
      end
      reset_reset = 1'b0;
      clear_model();
      wait_pct = 0;
   endtask

   task automatic test_illegal_cmd();
      do_reset();
      r_rd[0]   = 1'b1;
      r_wr[0]   = 1'b1;
      r_addr[0] = 25'h0777777;
      r_wd[0]   = 8'h3C;
      step();
      checks++;
      if (m_read !== 1'b1 || m_write !== 1'b0 || r_wait[0] !== 1'b0) begin
         failures++;
         $display("FAIL illegal_issue got m_rd=%b m_wr=%b wait0=%b required 1 0 0", m_read, m_write, r_wait[0]);
      end
      r_rd[0] = 1'b0;
      r_wr[0] = 1'b0;
      step();
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL illegal_err got err=%b required 1", err);
      end
      drain();
   endtask

   task automatic test_random();
      do_reset();
      wait_pct    = 30;
      rdv_pct     = 60;
      req_mode[0] = 2;
      req_mode[1] = 2;
      repeat (600) step();
      drain();
   endtask

   initial begin
      reset_reset     = 1'b1;
      m_waitrequest   = 1'b1;
      m_readdata      = 8'h00;
      m_readdatavalid = 1'b0;
      clear_model();
      test_reset();
      test_single_write();
      test_contention();
      test_backpressure();
      test_pending_limit();
      test_errors();
      test_illegal_cmd();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester round-robin arbiter in front of the SoC's SDRAM controller Avalon-MM slave (8-bit data, 32 MB).
- Requester 0 is the weight/embedding fetch engine of the intent classifier; requester 1 is the host-side loader that writes model tables into SDRAM.
- Presents one Avalon-MM master to the SDRAM controller and tracks pipelined reads, so each requester gets only its own read data back, in order.

Parameters:
- ADDR_W, 25, byte address width (13 row + 2 bank + 10 col).
- DATA_W, 8, data width; matches the SDRAM DQ width.
- MAX_PEND, 4, maximum outstanding reads; power of two, at least 2.

Ports:
- clk_clk  in  1  system clock, the same clock as the SDRAM controller.
- reset_reset  in  1  synchronous active-high reset.
- rN_address  in  ADDR_W  requester N address (N = 0, 1, same for all rN_ ports).
- rN_read  in  1  requester N read request.
- rN_write  in  1  requester N write request.
- rN_writedata  in  DATA_W  requester N write data.
- rN_waitrequest  out  1  low for exactly the accept cycle.
- rN_readdata  out  DATA_W  returned read data.
- rN_readdatavalid  out  1  one-cycle strobe for rN_readdata.
- m_address  out  ADDR_W  to the SDRAM controller.
- m_read  out  1  to the SDRAM controller.
- m_write  out  1  to the SDRAM controller.
- m_writedata  out  DATA_W  to the SDRAM controller.
- m_waitrequest  in  1  from the SDRAM controller.
- m_readdata  in  DATA_W  from the SDRAM controller.
- m_readdatavalid  in  1  from the SDRAM controller.
- err  out  1  sticky protocol-error flag.

Behaviour:
- One clock (clk_clk); reset_reset is synchronous and active-high.
- Reset values:
  - state IDLE, priority pointer = 0 (r0 favoured), ID FIFO empty, err = 0.
  - m_read, m_write, rN_readdatavalid = 0; m_address, m_writedata, rN_readdata = 0.
  - rN_waitrequest = 1.
- FSM IDLE:
  - Candidate = requester with read or write asserted. A read candidate is eligible only while pend_cnt < MAX_PEND; writes are never blocked.
  - If both are eligible, the one not equal to the priority pointer loses. The pointer names the favoured requester and is initially 0.
  - On a grant: register address, writedata, read/write and grant ID into the m_ registers, then go to ISSUE.
  - No eligible candidate: stay in IDLE.
- FSM ISSUE:
  - m_ outputs are held stable.
  - In a cycle with m_waitrequest = 0, the command is accepted. That same cycle: r[gnt]_waitrequest = 0 (combinational), and the ID is pushed to the FIFO if the command is a read.
  - The priority pointer then moves to the other requester; next cycle m_read/m_write = 0 and the FSM returns to IDLE.
  - Peak throughput is one command per 2 cycles.
- rN_waitrequest = 1 in every cycle except its accept cycle. A requester holds its command stable while waitrequest is high.
- Read return:
  - On m_readdatavalid, pop the FIFO head ID.
  - Next cycle: r[ID]_readdata = m_readdata and r[ID]_readdatavalid = 1 for one cycle. Return latency is 1 cycle after m_readdatavalid.
  - rN_readdata holds its last value otherwise.
- FIFO: MAX_PEND entries of 1-bit ID, with wrap-around pointers and pend_cnt of clog2(MAX_PEND)+1 bits.
  - Push and pop in the same cycle: count unchanged. Pop at MAX_PEND while pushing is legal.
  - A read is not granted when pend_cnt == MAX_PEND, even if the same cycle's pop would free a slot; it is retried next cycle.
- Errors (err stays set until reset):
  - m_readdatavalid with the FIFO empty: data dropped, err set.
  - A requester asserting read and write together: treated as a read, err set.
- Reset mid-operation: any pending command is abandoned and the FIFO is cleared. The SDRAM controller shares the reset, so no returns arrive afterwards; any that do set err.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - ADDR_W and DATA_W defaults;
  - typedef req_id_t (1 bit);
  - the FSM enum arb_state_t {IDLE, ISSUE}.
- One sub-module, sdram_rd_id_fifo: a parameterised MAX_PEND-deep ID FIFO with push, pop, head, count, full and empty.
- The arbiter FSM and return routing stay in sdram_port_arbiter.

Test Plan:
- Single write: r1 writes 0x0123456 = 0xA5, m_waitrequest low. Required: m_write asserted 1 cycle after the request; r1_waitrequest low in that same cycle; m_address = 0x0123456, m_writedata = 0xA5; FSM back in IDLE the next cycle.
- Contention: r0 and r1 both read continuously after reset. Required: grants alternate r0, r1, r0, r1; each rN_readdatavalid carries the data the model SDRAM returned for that requester's address, in order.
- Backpressure: m_waitrequest held high for 5 cycles during an r0 read. Required: m_ outputs stable for all 5 cycles; r0_waitrequest stays high until the cycle m_waitrequest falls.
- Pending limit: readdatavalid withheld, 5 reads issued. Required: 4 reads accepted and the 5th stalls. One m_readdatavalid then yields rN_readdatavalid on the next cycle, and the 5th read is accepted afterwards.
- Errors:
  - m_readdatavalid with no reads outstanding: err = 1 and no rN_readdatavalid.
  - Reset asserted: err = 0, both rN_waitrequest = 1, m_read = m_write = 0 on the next cycle.
- Illegal command: r0 asserts read and write together. Required: a read is issued and err = 1.
